ram_pipe: RTL and testbench
===========================

Name: ram_pipe

Overview:
Parametrised successor to the 256x16 single-port ram used by the CPU core. Adds a valid/ready request interface, a configurable registered read latency and a hardware clear sequencer. Sits between the control FSM/MAR/MDR datapath and storage. The storage array is named mem so testbenches can preload it hierarchically with $readmemh and inspect it.

Parameters:
DATA_W, 16, data word width in bits
ADDR_W, 8, address width; depth = 2**ADDR_W
RD_LAT, 1, read latency in cycles (legal 1..4; any other value is an elaboration error)
CLR_EN, 1, 1 = sweep the whole array to CLR_VAL after reset; 0 = skip the clear and go straight to RUN
CLR_VAL, 0, word written to every location during a clear

Ports:
clk  in  1  clock, all logic on the rising edge
rst  in  1  synchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  block accepts a request this cycle
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  request address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  read data valid, one-cycle pulse per read
rsp_rdata  out  DATA_W  read data
clr_start  in  1  software clear request, sampled in RUN only
busy  out  1  high while a clear is in progress

Behaviour:
- Reset (rst==0 at an edge):
  - state <= CLEAR if CLR_EN, else RUN.
  - clr_cnt <= 0.
  - All read-pipe valid bits <= 0.
  - rsp_valid <= 0 and rsp_rdata <= 0.
  - mem contents are not reset.
  - Reset asserted mid-clear restarts the clear from address 0.
- Outputs are decoded from the state: req_ready = (state==RUN); busy = (state==CLEAR).
- CLEAR:
  - Each cycle: mem[clr_cnt] <= CLR_VAL and clr_cnt increments.
  - After writing address 2**ADDR_W-1, clr_cnt wraps to 0 and state -> RUN.
  - A clear therefore takes exactly 2**ADDR_W cycles.
  - req_valid and clr_start are ignored in CLEAR.
- RUN:
  - A request is accepted at an edge where req_valid && req_ready.
  - Write: mem[req_addr] <= req_wdata at the accepting edge. A write produces no response.
  - Read: mem[req_addr] is captured into pipe stage 1 at the accepting edge, then shifts one stage per cycle.
  - rsp_valid is high for exactly one cycle, RD_LAT cycles after the accepting edge. With RD_LAT=1, rsp_valid is high in the cycle right after the accepting edge.
  - Throughput is one request per cycle. There is no response backpressure.
  - rsp_rdata holds its last value while rsp_valid is low.
- Read-after-write: a write accepted at edge k followed by a read of the same address accepted at edge k+1 returns the new data.
- clr_start:
  - When clr_start is high at an edge in RUN, state -> CLEAR at that edge and clr_cnt starts at 0.
  - A request accepted at that same edge completes normally: a write lands before the sweep; a read returns pre-clear data.
  - Reads already in the pipe drain normally with the data captured at their acceptance.
- Widths: addresses are taken mod 2**ADDR_W. clr_cnt is ADDR_W bits and wraps naturally.

Test Plan:
- Reset clear, defaults: hold rst=0 for 2 cycles, preload mem[0x0c]=0xABCD, release rst -> busy=1 and req_ready=0 for exactly 256 cycles, then busy=0 and req_ready=1; mem[0x0c]=0x0000.
- Write then read, RD_LAT=1: write 0x000F to 0x0c, then read 0x0c on the next cycle -> rsp_valid is a single pulse one cycle after the read is accepted, with rsp_rdata=0x000F.
- Back-to-back reads, RD_LAT=3, addresses 0..3 preloaded with 0x11,0x22,0x33,0x44: four consecutive reads of 0..3 -> rsp_valid high for 4 consecutive cycles starting 3 cycles after the first accept; data 0x11,0x22,0x33,0x44 in order.
- clr_start with an in-flight read, RD_LAT=2: mem[5]=0x5555; read 5 accepted at the same edge clr_start=1 -> response returns 0x5555; busy high for 256 cycles; a read of 5 afterwards returns 0x0000.
- Reset mid-clear: assert rst=0 at clr_cnt=100 for one cycle -> clear restarts at address 0 and busy stays high for a further 256 cycles after rst returns to 1.
- CLR_EN=0 with $readmemh preload: release rst -> req_ready=1 on the first cycle; the preloaded contents are intact (mem[2] reads back the value from the list file).

Source files
------------

// File: rtl/ram_pipe.sv
// Single-port RAM with valid/ready requests, a registered read pipe
// of RD_LAT stages and a full-array clear sequencer.
module ram_pipe #(
    parameter int          DATA_W  = 16,
    parameter int          ADDR_W  = 8,
    parameter int          RD_LAT  = 1,
    parameter int          CLR_EN  = 1,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              clr_start,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_lat_chk
        $error("ram_pipe: RD_LAT must be in 1..4");
    end

    typedef enum logic {
        S_RUN,
        S_CLEAR
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [RD_LAT-1:0]   vld_q, vld_d;
    logic [DATA_W-1:0]   dat_q [RD_LAT];
    logic [DATA_W-1:0]   dat_d [RD_LAT];
    logic                accept;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= (CLR_EN != 0) ? S_CLEAR : S_RUN;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            S_RUN: begin
                if (clr_start) begin
                    state_d   = S_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            S_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == '1) state_d = S_RUN;
            end
        endcase
    end

    always_comb begin
        req_ready = (state_q == S_RUN);
        busy      = (state_q == S_CLEAR);
    end

    assign accept = req_valid && req_ready;

    // Storage is never reset; writes are held off while rst is asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (busy) begin
                mem[clr_cnt_q] <= CLR_VAL;
            end else if (accept && req_we) begin
                mem[req_addr] <= req_wdata;
            end
        end
    end

    // Data regs load only with their valid, so the last stage holds its value.
    always_comb begin
        vld_d[0] = accept && !req_we;
        dat_d[0] = vld_d[0] ? mem[req_addr] : dat_q[0];
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign rsp_valid = vld_q[RD_LAT-1];
    assign rsp_rdata = dat_q[RD_LAT-1];

endmodule

// File: tb/tb_ram_pipe.sv
// Bench for ram_pipe: three clearing instances (RD_LAT 1..3) share one
// stimulus and a reference memory; a fourth instance runs without clear.
module tb_ram_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, clr_start;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic [2:0]  rdy, bsy, rv;
    logic [15:0] rd [3];

    logic        v0;
    logic [7:0]  a0;
    logic        rdy0, bsy0, rv0;
    logic [15:0] rd0;
    logic        zero_b;
    logic [15:0] zero_w;

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic [15:0] mdl [256];
    bit          done_chk = 1'b0;

    typedef struct {
        int          due;
        logic [15:0] d;
    } exp_t;

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst && req_valid && req_we) mdl[req_addr] <= req_wdata;
    end

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = g + 1;
        exp_t        q[$];
        exp_t        e;
        logic [15:0] last;

        ram_pipe #(.RD_LAT(L)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid),
            .req_ready (rdy[g]),
            .req_we    (req_we),
            .req_addr  (req_addr),
            .req_wdata (req_wdata),
            .rsp_valid (rv[g]),
            .rsp_rdata (rd[g]),
            .clr_start (clr_start),
            .busy      (bsy[g])
        );

        always @(posedge clk) begin
            if (!rst) q.delete();
            else if (req_valid && !req_we)
                q.push_back('{cyc + L, mdl[req_addr]});
        end

        always @(negedge clk) begin
            if (!rst) begin
                last = '0;
            end else if (rv[g]) begin
                if (q.size() == 0) begin
                    check($sformatf("spur%0d", g), 32'(q.size()), 32'd1);
                end else begin
                    e = q.pop_front();
                    check($sformatf("lat%0d", g), 32'(cyc), 32'(e.due));
                    check($sformatf("data%0d", g), 32'(rd[g]), 32'(e.d));
                    last = e.d;
                end
            end else begin
                check($sformatf("hold%0d", g), 32'(rd[g]), 32'(last));
                if (q.size() > 0 && q[0].due < cyc) begin
                    check($sformatf("miss%0d", g), 32'(rv[g]), 32'd1);
                    void'(q.pop_front());
                end
            end
        end

        always @(posedge done_chk)
            check($sformatf("drain%0d", g), 32'(q.size()), 32'd0);
    end

    ram_pipe #(.RD_LAT(1), .CLR_EN(0)) u_d0 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (v0),
        .req_ready (rdy0),
        .req_we    (zero_b),
        .req_addr  (a0),
        .req_wdata (zero_w),
        .rsp_valid (rv0),
        .rsp_rdata (rd0),
        .clr_start (zero_b),
        .busy      (bsy0)
    );

    task automatic wait_clear(string tag);
        int n = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            check({tag, "_rdy"}, 32'(rdy), 32'(3'(~bsy)));
            if (bsy != 3'b111) break;
            n++;
        end
        check(tag, 32'(n), 32'd256);
        check({tag, "_end"}, 32'(bsy), 32'd0);
    endtask

    task automatic req(bit we, logic [7:0] a, logic [15:0] d);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; clr_start = 1'b0; v0 = 1'b0; a0 = '0;
        zero_b = 1'b0; zero_w = '0;
        repeat (2) @(posedge clk);
        #1;
        g_dut[0].u_dut.mem[12] = 16'hABCD;
        g_dut[1].u_dut.mem[12] = 16'hABCD;
        g_dut[2].u_dut.mem[12] = 16'hABCD;
        u_d0.mem[2] = 16'hBEEF;
        @(negedge clk);
        check("rst_rv", 32'(rv), 32'd0);
        check("rst_rd", 32'(rd[2]), 32'd0);
        check("rst_busy", 32'(bsy), 32'h7);
        check("rst_rdy", 32'(rdy), 32'd0);
        check("rst_rdy0", 32'(rdy0), 32'd1);
        check("rst_busy0", 32'(bsy0), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        wait_clear("rstclr");
        check("clr_m0", 32'(g_dut[0].u_dut.mem[12]), 32'd0);
        check("clr_m1", 32'(g_dut[1].u_dut.mem[12]), 32'd0);
        check("clr_m2", 32'(g_dut[2].u_dut.mem[12]), 32'd0);
        for (int i = 0; i < 256; i++) mdl[i] = '0;

        v0 = 1'b1; a0 = 8'd2;
        @(negedge clk);
        v0 = 1'b0;
        check("nc_rv", 32'(rv0), 32'd1);
        check("nc_rd", 32'(rd0), 32'hBEEF);

        req(1'b1, 8'h0c, 16'h000F);
        req(1'b0, 8'h0c, 16'h0);
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) req(1'b1, 8'(i), 16'(8'h11 * (i + 1)));
        for (int i = 0; i < 4; i++) req(1'b0, 8'(i), 16'h0);
        for (int i = 0; i < 40; i++)
            req(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
                16'($urandom));
        repeat (6) @(posedge clk);
        #1;

        req(1'b1, 8'd5, 16'h5555);
        clr_start = 1'b1;
        req(1'b0, 8'd5, 16'h0);
        clr_start = 1'b0;
        for (int i = 0; i < 256; i++) mdl[i] = '0;
        wait_clear("swclr");
        req(1'b0, 8'd5, 16'h0);
        repeat (6) @(posedge clk);
        #1;

        clr_start = 1'b1;
        @(posedge clk);
        #1 clr_start = 1'b0;
        repeat (100) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        wait_clear("midrst");
        req(1'b1, 8'd9, 16'h1234);
        req(1'b0, 8'd9, 16'h0);
        repeat (8) @(posedge clk);
        done_chk = 1'b1;
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
